mmu_arbiter: RTL and testbench

Shares the single sequential TLB-lookup MMU between the instruction-fetch port and the data-access port. It accepts level-held requests from both ports, grants one at a time with round-robin priority, and latches the virtual address. It issues a single-cycle `mmu_start` pulse, holds `mmu_vaddr` stable for the whole lookup, and returns the physical address and miss flag to the granted requester. A watchdog converts a lookup that never completes into a reported miss, and it drains any late completion so the late result is never attributed to a later request.

---
 rtl/mmu_arbiter_if.sv | 37 +++
 rtl/mmu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mmu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared MMU.
interface mmu_arbiter_if;
  logic        if_req;
  logic [31:0] if_vaddr;
  logic        if_ack;
  logic [31:0] if_paddr;
  logic        if_miss;
  logic        d_req;
  logic [31:0] d_vaddr;
  logic        d_ack;
  logic [31:0] d_paddr;
  logic        d_miss;
  logic        mmu_start;
  logic [31:0] mmu_vaddr;
  logic [31:0] mmu_paddr;
  logic        mmu_done;
  logic        mmu_hit;
  logic        mmu_miss;
  logic        busy;
  logic        timeout_err;

  // Arbiter side.
  modport slave (
    input  if_req, if_vaddr, d_req, d_vaddr,
    input  mmu_paddr, mmu_done, mmu_hit, mmu_miss,
    output if_ack, if_paddr, if_miss, d_ack, d_paddr, d_miss,
    output mmu_start, mmu_vaddr, busy, timeout_err
  );

  // Requester / MMU environment side.
  modport master (
    output if_req, if_vaddr, d_req, d_vaddr,
    output mmu_paddr, mmu_done, mmu_hit, mmu_miss,
    input  if_ack, if_paddr, if_miss, d_ack, d_paddr, d_miss,
    input  mmu_start, mmu_vaddr, busy, timeout_err
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one sequential TLB-lookup MMU between the
// instruction-fetch and data ports, with a watchdog that turns a hung lookup
// into a reported miss and drains any late completion before the next grant.
module mmu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  mmu_arbiter_if.slave  bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic [2:0]        state, state_nxt;
  logic              owner, owner_nxt;
  logic              last_grant, last_grant_nxt;
  logic              flush_pending, flush_pending_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] vaddr_q, vaddr_nxt;
  logic              start_q, start_nxt;
  logic              if_ack_q, if_ack_nxt;
  logic [ADDR_W-1:0] if_paddr_q, if_paddr_nxt;
  logic              if_miss_q, if_miss_nxt;
  logic              d_ack_q, d_ack_nxt;
  logic [ADDR_W-1:0] d_paddr_q, d_paddr_nxt;
  logic              d_miss_q, d_miss_nxt;
  logic              busy_q, busy_nxt;
  logic              terr_q, terr_nxt;

  logic              grant_d_c;
  logic              res_miss_c;
  logic [ADDR_W-1:0] res_paddr_c;

  // Data port wins when it is the only requester or when instruction went last.
  assign grant_d_c = bus.d_req && (!bus.if_req || (last_grant == PORT_I));

  // Lookup result; absence of mmu_done here means the watchdog fired.
  assign res_miss_c  = !bus.mmu_done || bus.mmu_miss || !bus.mmu_hit;
  assign res_paddr_c = res_miss_c ? '0 : bus.mmu_paddr;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt         = state;
    owner_nxt         = owner;
    last_grant_nxt    = last_grant;
    flush_pending_nxt = flush_pending;
    cnt_nxt           = cnt;
    vaddr_nxt         = vaddr_q;
    start_nxt         = 1'b0;
    if_ack_nxt        = 1'b0;
    if_paddr_nxt      = if_paddr_q;
    if_miss_nxt       = if_miss_q;
    d_ack_nxt         = 1'b0;
    d_paddr_nxt       = d_paddr_q;
    d_miss_nxt        = d_miss_q;
    busy_nxt          = 1'b0;
    terr_nxt          = terr_q;

    case (state)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_nxt = grant_d_c;
          vaddr_nxt = grant_d_c ? bus.d_vaddr : bus.if_vaddr;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mmu_done || (cnt == CNT_LAST)) begin
          state_nxt = S_RESP;
          if (!bus.mmu_done) begin
            terr_nxt          = 1'b1;
            flush_pending_nxt = 1'b1;
          end
          if (owner == PORT_D) begin
            d_ack_nxt   = 1'b1;
            d_paddr_nxt = res_paddr_c;
            d_miss_nxt  = res_miss_c;
          end else begin
            if_ack_nxt   = 1'b1;
            if_paddr_nxt = res_paddr_c;
            if_miss_nxt  = res_miss_c;
          end
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_grant_nxt    = owner;
        cnt_nxt           = '0;
        flush_pending_nxt = 1'b0;
        state_nxt         = flush_pending ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        // Swallow one stale completion so it is never credited to a new owner.
        if (bus.mmu_done || (cnt == CNT_LAST)) begin
          state_nxt = S_IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    start_nxt = (state_nxt == S_ISSUE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      owner         <= PORT_I;
      last_grant    <= PORT_D;
      flush_pending <= 1'b0;
      cnt           <= '0;
      vaddr_q       <= '0;
      start_q       <= 1'b0;
      if_ack_q      <= 1'b0;
      if_paddr_q    <= '0;
      if_miss_q     <= 1'b0;
      d_ack_q       <= 1'b0;
      d_paddr_q     <= '0;
      d_miss_q      <= 1'b0;
      busy_q        <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      last_grant    <= last_grant_nxt;
      flush_pending <= flush_pending_nxt;
      cnt           <= cnt_nxt;
      vaddr_q       <= vaddr_nxt;
      start_q       <= start_nxt;
      if_ack_q      <= if_ack_nxt;
      if_paddr_q    <= if_paddr_nxt;
      if_miss_q     <= if_miss_nxt;
      d_ack_q       <= d_ack_nxt;
      d_paddr_q     <= d_paddr_nxt;
      d_miss_q      <= d_miss_nxt;
      busy_q        <= busy_nxt;
      terr_q        <= terr_nxt;
    end
  end

  assign bus.mmu_start   = start_q;
  assign bus.mmu_vaddr   = vaddr_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.if_paddr    = if_paddr_q;
  assign bus.if_miss     = if_miss_q;
  assign bus.d_ack       = d_ack_q;
  assign bus.d_paddr     = d_paddr_q;
  assign bus.d_miss      = d_miss_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter: per-cycle vector table for the simple
// lookups, hand-written sequences for arbitration, timeout/drain and reset.
module tb_mmu_arbiter;

  localparam int unsigned T_CYC = 32;
  localparam logic [31:0] A = 32'h8000_1234;
  localparam logic [31:0] B = 32'h4000_0abc;

  logic clk;
  logic reset;

  mmu_arbiter_if bus ();

  mmu_arbiter #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iva;
    logic        dreq;
    logic [31:0] dva;
    logic        done;
    logic        hit;
    logic        miss;
    logic [31:0] pa;
    logic        e_start;
    logic [31:0] e_mva;
    logic        e_iack;
    logic        e_dack;
    logic        e_miss;
    logic [31:0] e_pa;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  int n_pass = 0;
  int n_total = 0;
  int cd = 0;
  int lat = 2;
  bit auto_mmu = 1'b0;

  function automatic vec_t mk(logic ireq, logic [31:0] iva, logic dreq, logic [31:0] dva,
                              logic done, logic hit, logic miss, logic [31:0] pa,
                              logic e_start, logic [31:0] e_mva, logic e_iack, logic e_dack,
                              logic e_miss, logic [31:0] e_pa, logic e_busy);
    vec_t r;
    r.ireq = ireq;  r.iva = iva;  r.dreq = dreq;  r.dva = dva;
    r.done = done;  r.hit = hit;  r.miss = miss;  r.pa = pa;
    r.e_start = e_start;  r.e_mva = e_mva;  r.e_iack = e_iack;  r.e_dack = e_dack;
    r.e_miss = e_miss;  r.e_pa = e_pa;  r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, got, exp);
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, got, exp);
  endtask

  // Advance to the middle of the next cycle; optional MMU model answers
  // 'lat' cycles after the start pulse with an identity-mapped hit.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      cd = 0;
    end else if (auto_mmu) begin
      bus.mmu_done = 1'b0;
      if (cd != 0) begin
        cd--;
        if (cd == 0) begin
          bus.mmu_done  = 1'b1;
          bus.mmu_hit   = 1'b1;
          bus.mmu_miss  = 1'b0;
          bus.mmu_paddr = bus.mmu_vaddr;
        end
      end
      if (bus.mmu_start) cd = lat;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk1 ({tag, " if_ack"},    bus.if_ack,      1'b0);
    chk1 ({tag, " d_ack"},     bus.d_ack,       1'b0);
    chk1 ({tag, " if_miss"},   bus.if_miss,     1'b0);
    chk1 ({tag, " d_miss"},    bus.d_miss,      1'b0);
    chk32({tag, " if_paddr"},  bus.if_paddr,    32'h0);
    chk32({tag, " d_paddr"},   bus.d_paddr,     32'h0);
    chk32({tag, " mmu_vaddr"}, bus.mmu_vaddr,   32'h0);
    chk1 ({tag, " mmu_start"}, bus.mmu_start,   1'b0);
    chk1 ({tag, " busy"},      bus.busy,        1'b0);
    chk1 ({tag, " terr"},      bus.timeout_err, 1'b0);
  endtask

  initial begin
    vec_t        r;
    logic [31:0] starts [4];
    int          ack_port [4];
    int          ack_cyc [4];
    int          ns;
    int          na;
    logic [31:0] exp_va [4];

    // MMU off, single instruction request: done in cycle 3, ack in cycle 4.
    vecs.push_back(mk(1'b1, A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    vecs.push_back(mk(1'b1, A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, A,     1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, A,     1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, A, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, A,     1'b0, A,     1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, A, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, A,     1'b1, 1'b0, 1'b0, A,     1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, A, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    // TLB miss on the data port: done+miss in cycle 20, ack in cycle 21.
    for (int c = 0; c <= 22; c++) begin
      vecs.push_back(mk(1'b0, 32'h0, c < 22, (c < 22) ? B : 32'h0,
                        c == 20, 1'b0, c == 20, 32'hdead_beef,
                        c == 1, (c == 0) ? A : B, 1'b0, c == 21,
                        c == 21, 32'h0, (c >= 1) && (c <= 21)));
    end

    reset = 1'b1;
    bus.if_req = 1'b0;  bus.if_vaddr = 32'h0;
    bus.d_req = 1'b0;   bus.d_vaddr = 32'h0;
    bus.mmu_done = 1'b0; bus.mmu_hit = 1'b0; bus.mmu_miss = 1'b0; bus.mmu_paddr = 32'h0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      tick();
      chk1 ($sformatf("row%0d mmu_start", i), bus.mmu_start, r.e_start);
      chk32($sformatf("row%0d mmu_vaddr", i), bus.mmu_vaddr, r.e_mva);
      chk1 ($sformatf("row%0d if_ack", i),    bus.if_ack,    r.e_iack);
      chk1 ($sformatf("row%0d d_ack", i),     bus.d_ack,     r.e_dack);
      chk1 ($sformatf("row%0d busy", i),      bus.busy,      r.e_busy);
      chk1 ($sformatf("row%0d terr", i),      bus.timeout_err, 1'b0);
      if (r.e_iack) begin
        chk32($sformatf("row%0d if_paddr", i), bus.if_paddr, r.e_pa);
        chk1 ($sformatf("row%0d if_miss", i),  bus.if_miss,  r.e_miss);
      end
      if (r.e_dack) begin
        chk32($sformatf("row%0d d_paddr", i), bus.d_paddr, r.e_pa);
        chk1 ($sformatf("row%0d d_miss", i),  bus.d_miss,  r.e_miss);
      end
      bus.if_req = r.ireq;  bus.if_vaddr = r.iva;
      bus.d_req = r.dreq;   bus.d_vaddr = r.dva;
      bus.mmu_done = r.done; bus.mmu_hit = r.hit; bus.mmu_miss = r.miss; bus.mmu_paddr = r.pa;
    end

    // Simultaneous requests after reset: strict alternation, 5 cycles each.
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    bus.mmu_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    auto_mmu = 1'b1; lat = 2; cd = 0;
    bus.if_req = 1'b1; bus.if_vaddr = 32'h0000_1000;
    bus.d_req = 1'b1;  bus.d_vaddr = 32'h0000_2000;
    ns = 0; na = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      chk1($sformatf("rr c%0d dual ack", c), bus.if_ack & bus.d_ack, 1'b0);
      if (bus.mmu_start) begin
        if (ns < 4) starts[ns] = bus.mmu_vaddr;
        ns++;
      end
      if (bus.if_ack) begin
        chk32($sformatf("rr c%0d if_paddr", c), bus.if_paddr, 32'h0000_1000);
        if (na < 4) begin ack_port[na] = 0; ack_cyc[na] = c; end
        na++;
      end
      if (bus.d_ack) begin
        chk32($sformatf("rr c%0d d_paddr", c), bus.d_paddr, 32'h0000_2000);
        if (na < 4) begin ack_port[na] = 1; ack_cyc[na] = c; end
        na++;
      end
      if (na >= 4) begin
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    chk32("rr start count", 32'(ns), 32'd4);
    chk32("rr ack count", 32'(na), 32'd4);
    exp_va = '{32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
    for (int i = 0; i < 4; i++) begin
      chk32($sformatf("rr vaddr%0d", i), (i < ns) ? starts[i] : 32'hxxxx_xxxx, exp_va[i]);
      chk32($sformatf("rr port%0d", i), (i < na) ? 32'(ack_port[i]) : 32'hffff_ffff, 32'(i % 2));
      chk32($sformatf("rr ackcyc%0d", i), (i < na) ? 32'(ack_cyc[i]) : 32'hffff_ffff, 32'(4 + 5 * i));
    end

    // Timeout, late completion drained, second request waits for FLUSH exit.
    auto_mmu = 1'b0; cd = 0;
    bus.mmu_done = 1'b0;
    bus.if_req = 1'b1; bus.if_vaddr = 32'h00aa_0000;
    for (int c = 1; c <= 46; c++) begin
      tick();
      chk1($sformatf("to c%0d mmu_start", c), bus.mmu_start, (c == 1) || (c == 42));
      chk1($sformatf("to c%0d if_ack", c), bus.if_ack, (c == 34) || (c == 45));
      chk1($sformatf("to c%0d d_ack", c), bus.d_ack, 1'b0);
      chk1($sformatf("to c%0d busy", c), bus.busy, (c != 41) && (c < 46));
      if (c == 33) chk1("to terr before expiry", bus.timeout_err, 1'b0);
      if (c == 34) begin
        chk1 ("to timeout if_miss", bus.if_miss, 1'b1);
        chk32("to timeout if_paddr", bus.if_paddr, 32'h0);
        chk1 ("to timeout terr", bus.timeout_err, 1'b1);
      end
      if (c == 45) begin
        chk32("to second if_paddr", bus.if_paddr, 32'h00bb_0000);
        chk1 ("to second if_miss", bus.if_miss, 1'b0);
        chk1 ("to terr sticky", bus.timeout_err, 1'b1);
      end
      if (c == 35) bus.if_vaddr = 32'h00bb_0000;
      if (!auto_mmu) begin
        bus.mmu_done  = (c == 40);
        bus.mmu_hit   = (c == 40);
        bus.mmu_miss  = 1'b0;
        bus.mmu_paddr = 32'h1234_5678;
      end
      if (c == 41) begin auto_mmu = 1'b1; lat = 2; cd = 0; end
      if (c == 45) bus.if_req = 1'b0;
    end

    // Reset in the middle of a lookup, then a fresh MMU-off request.
    auto_mmu = 1'b0; cd = 0;
    bus.mmu_done = 1'b0;
    bus.if_req = 1'b1; bus.if_vaddr = 32'h5555_0000;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 5) chk1("rst busy before", bus.busy, 1'b1);
      if (c == 6) check_reset_values("rst mid-wait");
      if (c < 10) begin
        chk1($sformatf("rst c%0d if_ack", c), bus.if_ack, 1'b0);
        chk1($sformatf("rst c%0d d_ack", c), bus.d_ack, 1'b0);
      end
      if (c == 7) begin
        chk1 ("rst regrant start", bus.mmu_start, 1'b1);
        chk32("rst regrant vaddr", bus.mmu_vaddr, 32'h0000_6000);
      end
      if (c == 10) begin
        chk1 ("rst fresh if_ack", bus.if_ack, 1'b1);
        chk32("rst fresh if_paddr", bus.if_paddr, 32'h0000_6000);
        chk1 ("rst fresh if_miss", bus.if_miss, 1'b0);
      end
      if (c == 11) chk1("rst idle busy", bus.busy, 1'b0);
      if (c == 5) reset = 1'b1;
      if (c == 6) begin
        reset = 1'b0;
        bus.if_vaddr = 32'h0000_6000;
        auto_mmu = 1'b1; lat = 2; cd = 0;
      end
      if (c == 10) bus.if_req = 1'b0;
    end

    // Requester changes its address mid-lookup; latched address must hold.
    lat = 6; cd = 0;
    bus.if_req = 1'b1; bus.if_vaddr = 32'h0000_7000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c <= 8) chk32($sformatf("stab c%0d mmu_vaddr", c), bus.mmu_vaddr, 32'h0000_7000);
      chk1($sformatf("stab c%0d if_ack", c), bus.if_ack, c == 8);
      if (c == 8) begin
        chk32("stab if_paddr", bus.if_paddr, 32'h0000_7000);
        chk1 ("stab if_miss", bus.if_miss, 1'b0);
      end
      if (c == 9) chk1("stab idle busy", bus.busy, 1'b0);
      if (c == 3) bus.if_vaddr = 32'hffff_ffff;
      if (c == 8) bus.if_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
